// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c_master command interface between two clients.
// Grants ownership round-robin, muxes command/data-handshake signals to and
// from the granted client, and holds a GAP interval between ownerships so the
// master can finish its STOP before the next start.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN (hold timeout with per-client lockout).
//
// Ports:
//   clk, reset (async, active-low)
//   req0/req1 in, gnt0/gnt1 out       ownership request / registered grant
//   c0_*/c1_* in                      client command fields
//   c0_*/c1_* out                     master responses routed to granted client
//   i2c_* out / in                    master command interface
//   busy, owner, timeout out          status
module i2c_arbiter #(
  parameter int unsigned GAP_CYCLES   = 1000,
  parameter int unsigned HOLD_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       c0_start,
  input  logic       c1_start,
  input  logic [6:0] c0_slave_addr,
  input  logic [6:0] c1_slave_addr,
  input  logic       c0_rw,
  input  logic       c1_rw,
  input  logic [7:0] c0_nbytes,
  input  logic [7:0] c1_nbytes,
  input  logic [7:0] c0_write_data,
  input  logic [7:0] c1_write_data,
  output logic [7:0] c0_read_data,
  output logic [7:0] c1_read_data,
  output logic       c0_tx_data_req,
  output logic       c1_tx_data_req,
  output logic       c0_rx_data_ready,
  output logic       c1_rx_data_ready,
  output logic       i2c_start,
  output logic [6:0] i2c_slave_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_nbytes,
  output logic [7:0] i2c_write_data,
  input  logic [7:0] i2c_read_data,
  input  logic       i2c_tx_data_req,
  input  logic       i2c_rx_data_ready,
  output logic       busy,
  output logic       owner,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  state_t      state, next;
  logic [23:0] gap_cnt;
  logic        elig0, elig1;

  // Elaboration-time parameter range guard.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 24'hFFFFFF ||
      HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 24'hFFFFFF) begin : g_param_check
    $error("i2c_arbiter: GAP_CYCLES/HOLD_TIMEOUT out of range 1..2^24-1");
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [23:0] hold_cnt;
  logic        lock0, lock1;
  logic        fire;

  assign elig0 = req0 & ~lock0;
  assign elig1 = req1 & ~lock1;
`else
  assign elig0   = req0;
  assign elig1   = req1;
  assign timeout = 1'b0;
`endif

  always_comb begin
    next = state;
`ifdef I2C_ARB_TIMEOUT_EN
    fire = 1'b0;
`endif
    case (state)
      IDLE: begin
        // owner remembers the last holder, so contention goes to the other one
        if (elig0 && elig1) next = owner ? GRANT0 : GRANT1;
        else if (elig0)     next = GRANT0;
        else if (elig1)     next = GRANT1;
      end
      GRANT0: begin
        if (!req0) next = GAP;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (hold_cnt == 24'(HOLD_TIMEOUT - 1)) begin
          next = GAP;
          fire = 1'b1;
        end
`endif
      end
      GRANT1: begin
        if (!req1) next = GAP;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (hold_cnt == 24'(HOLD_TIMEOUT - 1)) begin
          next = GAP;
          fire = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == '0) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= 1'b1;
      gap_cnt <= '0;
    end else begin
      state <= next;
      if (next == GRANT0) owner <= 1'b0;
      if (next == GRANT1) owner <= 1'b1;
      if (next == GAP && state != GAP) gap_cnt <= 24'(GAP_CYCLES - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 24'd1;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      lock0    <= 1'b0;
      lock1    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= fire;
      if (state != next) hold_cnt <= '0;
      else if (state == GRANT0 || state == GRANT1) hold_cnt <= hold_cnt + 24'd1;
      // A forced release always happens with req still high, so set and
      // clear of the same lock bit never coincide.
      if (fire && state == GRANT0) lock0 <= 1'b1;
      else if (!req0)              lock0 <= 1'b0;
      if (fire && state == GRANT1) lock1 <= 1'b1;
      else if (!req1)              lock1 <= 1'b0;
    end
  end
`endif

  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);
  assign busy = (state != IDLE);

  always_comb begin
    i2c_start        = 1'b0;
    i2c_slave_addr   = '0;
    i2c_rw           = 1'b0;
    i2c_nbytes       = '0;
    i2c_write_data   = '0;
    c0_read_data     = '0;
    c0_tx_data_req   = 1'b0;
    c0_rx_data_ready = 1'b0;
    c1_read_data     = '0;
    c1_tx_data_req   = 1'b0;
    c1_rx_data_ready = 1'b0;
    if (state == GRANT0) begin
      i2c_start        = c0_start;
      i2c_slave_addr   = c0_slave_addr;
      i2c_rw           = c0_rw;
      i2c_nbytes       = c0_nbytes;
      i2c_write_data   = c0_write_data;
      c0_read_data     = i2c_read_data;
      c0_tx_data_req   = i2c_tx_data_req;
      c0_rx_data_ready = i2c_rx_data_ready;
    end else if (state == GRANT1) begin
      i2c_start        = c1_start;
      i2c_slave_addr   = c1_slave_addr;
      i2c_rw           = c1_rw;
      i2c_nbytes       = c1_nbytes;
      i2c_write_data   = c1_write_data;
      c1_read_data     = i2c_read_data;
      c1_tx_data_req   = i2c_tx_data_req;
      c1_rx_data_ready = i2c_rx_data_ready;
    end
  end

endmodule
